// File: rtl/avalon_st_buffer.sv
// Avalon-ST circular buffer with registered head beat, flush,
// fill level reporting and a sticky packet-framing checker.
module avalon_st_buffer #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHANNEL_WIDTH   = 1,
  parameter int CAPACITY        = 2,
  parameter int ALMOST_FULL_LVL = CAPACITY - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CHANNEL_WIDTH-1:0]         in_channel,
  input  logic                             in_sop,
  input  logic                             in_eop,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CHANNEL_WIDTH-1:0]         out_channel,
  output logic                             out_sop,
  output logic                             out_eop,
  input  logic                             flush,
  output logic [$clog2(CAPACITY+1)-1:0]    fill_level,
  output logic                             almost_full,
  output logic                             pkt_err
);

  localparam int LW  = $clog2(CAPACITY + 1);
  localparam int PW  = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int AFL = (ALMOST_FULL_LVL < 1) ? 1 : ALMOST_FULL_LVL;
  localparam int BW  = DATA_WIDTH + CHANNEL_WIDTH + 2;

  localparam logic [LW-1:0] CAP_L = LW'(CAPACITY);
  localparam logic [LW-1:0] AF_L  = LW'(AFL);
  localparam logic [LW-1:0] ONE_L = LW'(1);
  localparam logic [PW-1:0] LAST  = PW'(CAPACITY - 1);

  typedef enum logic {IDLE, IN_PKT} pkt_state_t;

  logic [BW-1:0]            mem [CAPACITY];
  logic [BW-1:0]            in_beat;
  logic [BW-1:0]            head;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW-1:0]            wr_nxt, rd_nxt;
  logic [LW-1:0]            level, level_nxt;
  logic                     rdy_q;
  logic                     err_q;
  logic                     push, pop;
  logic [CHANNEL_WIDTH-1:0] pkt_ch;
  pkt_state_t               st;

  assign in_beat = {in_data, in_channel, in_sop, in_eop};
  assign push    = in_valid && rdy_q;
  assign pop     = (level != '0) && out_ready;
  assign wr_nxt  = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt  = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (!push && pop)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= in_beat;
  end

  // head mirrors mem[rd_ptr] so out_* come straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy_q  <= 1'b0;
      head   <= '0;
      st     <= IDLE;
      pkt_ch <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy_q  <= 1'b1;
      st     <= IDLE;
      err_q  <= 1'b0;
    end else begin
      level <= level_nxt;
      rdy_q <= level_nxt < CAP_L;
      if (push)
        wr_ptr <= wr_nxt;
      if (pop)
        rd_ptr <= rd_nxt;
      if (push && (level == '0 || (pop && level == ONE_L)))
        head <= in_beat;
      else if (pop && level > ONE_L)
        head <= mem[rd_nxt];
      if (push) begin
        unique case (1'b1)
          (st == IN_PKT) && !in_sop: begin
            if (in_channel != pkt_ch)
              err_q <= 1'b1;
            if (in_eop)
              st <= IDLE;
          end
          default: begin
            if (st == IN_PKT || !in_sop)
              err_q <= 1'b1;
            if (in_sop && !in_eop) begin
              st     <= IN_PKT;
              pkt_ch <= in_channel;
            end else begin
              st <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (level != '0);
  assign fill_level  = level;
  assign almost_full = (level >= AF_L);
  assign pkt_err     = err_q;
  assign {out_data, out_channel, out_sop, out_eop} = head;

endmodule

// File: doc/avalon_st_buffer.md
AVALON_ST_BUFFER -- requirements
Module: avalon_st_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of data payload.
REQ-002 SHALL have parameter CHANNEL_WIDTH, default 1: width of channel field.
REQ-003 SHALL have parameter CAPACITY, default 2: number of beats stored, legal range 1..16.
REQ-004 SHALL have parameter ALMOST_FULL_LVL, default CAPACITY-1: fill threshold for almost_full, legal range 1..CAPACITY.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have ports in_valid/in_ready, input/output, 1 each: sink handshake.
REQ-008 SHALL have ports in_data (DATA_WIDTH), in_channel (CHANNEL_WIDTH), in_sop (1), in_eop (1), all inputs: sink beat fields.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): source handshake.
REQ-010 SHALL have ports out_data, out_channel, out_sop, out_eop, all outputs, same widths as the sink fields: source beat fields.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all stored beats.
REQ-012 SHALL have port fill_level, output, $clog2(CAPACITY+1): beats currently stored.
REQ-013 SHALL have port almost_full, output, 1: high when fill_level >= ALMOST_FULL_LVL.
REQ-014 SHALL have port pkt_err, output, 1: sticky packet-framing error flag.

Function
REQ-015 SHALL accept a beat on a rising edge where in_valid && in_ready; SHALL release a beat on a rising edge where out_valid && out_ready.
REQ-016 SHALL drive in_ready = (fill_level < CAPACITY) from registers only; no combinational path from out_ready to in_ready.
REQ-017 SHALL drive out_valid = (fill_level != 0) and all out_* fields from registers; no combinational path from any in_* to any out_*.
REQ-018 SHALL deliver beats in acceptance order, with data, channel, sop and eop kept bit-exact.
REQ-019 Latency: a beat accepted into an empty buffer at edge N SHALL appear on out_* with out_valid=1 immediately after edge N.
REQ-020 Simultaneous accept and release at one edge SHALL leave fill_level unchanged and SHALL be legal at any fill level 1..CAPACITY-1.
REQ-021 When full, in_ready=0 and a release at edge N SHALL raise in_ready after edge N.
REQ-022 CAPACITY=1 SHALL be legal and SHALL give at most one beat every 2 cycles; CAPACITY>=2 SHALL sustain 1 beat/cycle with out_ready held high.
REQ-023 Storage SHALL be a circular buffer with read/write pointers wrapping from CAPACITY-1 to 0, including non-power-of-2 CAPACITY.
REQ-024 out_* fields while out_valid=0 SHALL be don't-care; out_data SHALL hold stable while out_valid && !out_ready.
REQ-025 Framing tracker SHALL have states IDLE and IN_PKT, evaluated on accepted input beats only.
REQ-026 In IDLE: sop=1,eop=1 stays in IDLE; sop=1,eop=0 goes to IN_PKT; sop=0 sets pkt_err and stays in IDLE.
REQ-027 In IN_PKT: eop=1,sop=0 goes to IDLE; sop=1 sets pkt_err and follows the IDLE rules for that beat; a change of in_channel versus the packet's first beat sets pkt_err.
REQ-028 Framing errors SHALL NOT block or alter data flow.
REQ-029 pkt_err SHALL clear only on rst or flush.
REQ-030 flush=1 at edge N SHALL set fill_level=0, set both pointers to 0, return the tracker to IDLE and clear pkt_err; a beat offered at edge N SHALL be discarded, and any release at edge N SHALL be ignored.
REQ-031 in_ready SHALL remain per REQ-016 during flush; the sink handshake completes and the beat is dropped.

Reset
REQ-032 rst=1 SHALL immediately and asynchronously force fill_level=0, out_valid=0, in_ready=0, almost_full=0, pkt_err=0, pointers=0, tracker=IDLE.
REQ-033 On the first clk edge after rst deasserts, in_ready SHALL be 1; in_ready SHALL stay 0 while rst is high.
REQ-034 Storage contents SHALL NOT require reset; out_data/out_channel/out_sop/out_eop reset to 0.
REQ-035 rst asserted mid-transfer SHALL discard all stored beats and SHALL NOT emit any beat after deassertion until a new beat is accepted.

Verification
REQ-036 CAPACITY=2, out_ready=1, in_valid=1 with data 1..20 -> out_data 1..20 in order, one per cycle, first beat one cycle after its accept.
REQ-037 CAPACITY=3, out_ready=0, push 4 beats -> 3 accepted, in_ready=0, fill_level=3, almost_full=1; one pop -> in_ready=1 next cycle.
REQ-038 CAPACITY=1, continuous traffic -> 10 beats take 20 cycles, in_ready alternates 1/0.
REQ-039 Beats sop=0 in IDLE, then sop=1,eop=0 ch=0 followed by ch=1 -> pkt_err=1 after the first beat, stays 1, and all data passes unchanged; flush -> pkt_err=0, fill_level=0.
REQ-040 CAPACITY=5, 12 beats with random out_ready stalls -> pointer wrap occurs, order preserved, fill_level never exceeds 5.
REQ-041 rst pulse asserted between clock edges with fill_level=2 -> out_valid=0 and in_ready=0 without waiting for an edge; nothing emitted after release.
